// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the pipeline memory stage: FSM states, beat
// index type and a helper that replaces one 32-bit word inside a vector.
package mem_stage_pkg;
  localparam int VEC_BEATS = 4;
  localparam int WORD_W    = 32;
  localparam int VEC_W     = 128;

  typedef logic [1:0] beat_t;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  function automatic logic [VEC_W-1:0] set_beat(input logic [VEC_W-1:0] v,
                                                input beat_t idx,
                                                input logic [WORD_W-1:0] w);
    logic [VEC_W-1:0] r;
    r = v;
    r[int'(idx)*WORD_W +: WORD_W] = w;
    return r;
  endfunction
endpackage

// File: rtl/memory_stage_if.sv
// Execute-side inputs, data-memory port and writeback packet of the memory
// stage; slave is the stage itself, master is whoever drives it.
interface memory_stage_if;
  import mem_stage_pkg::*;

  logic               in_valid, in_ready, stall;
  logic               MemRead, MemWrite, VecOp, RegWrite;
  logic [3:0]         Rd;
  logic [WORD_W-1:0]  ALUresult, WriteData;
  logic [VEC_W-1:0]   VALUresult;

  logic               mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [WORD_W-1:0]  mem_addr, mem_wdata, mem_rdata;

  logic               wb_valid, wb_RegWrite, wb_VecOp;
  logic [3:0]         wb_Rd;
  logic [WORD_W-1:0]  wb_data;
  logic [VEC_W-1:0]   wb_dataV;

  modport slave (
    input  in_valid, MemRead, MemWrite, VecOp, RegWrite, Rd, ALUresult,
           WriteData, VALUresult, mem_gnt, mem_rvalid, mem_rdata,
    output in_ready, stall, mem_req, mem_we, mem_addr, mem_wdata,
           wb_valid, wb_RegWrite, wb_VecOp, wb_Rd, wb_data, wb_dataV
  );

  modport master (
    output in_valid, MemRead, MemWrite, VecOp, RegWrite, Rd, ALUresult,
           WriteData, VALUresult, mem_gnt, mem_rvalid, mem_rdata,
    input  in_ready, stall, mem_req, mem_we, mem_addr, mem_wdata,
           wb_valid, wb_RegWrite, wb_VecOp, wb_Rd, wb_data, wb_dataV
  );
endinterface

// File: rtl/vec_beat_buffer.sv
// 4x32 beat register file: bulk-loaded with vector store data on accept,
// overwritten per beat by load data, read per beat for store data.
module vec_beat_buffer
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [VEC_W-1:0]  load_data,
  input  logic              wr_en,
  input  beat_t             wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  beat_t             rd_idx,
  output logic [WORD_W-1:0] rd_data,
  output logic [VEC_W-1:0]  data_o
);
  logic [VEC_BEATS-1:0][WORD_W-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (load_en)    slot_d         = load_data;
    else if (wr_en) slot_d[wr_idx] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  assign rd_data = slot_q[rd_idx];
  assign data_o  = slot_q;
endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: single-outstanding req/gnt/rvalid data access,
// vector ops as four 32-bit beats, registered one-cycle writeback packet.
module memory_stage
  import mem_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  memory_stage_if.slave   bus
);
  state_t            state_q, state_d;
  beat_t             beat_q, beat_d;
  logic [3:0]        rd_q, rd_d;
  logic              regwrite_q, regwrite_d, vec_q, vec_d, we_q, we_d;
  logic [WORD_W-1:0] alu_q, alu_d, wdata_q, wdata_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic              wb_valid_q, wb_valid_d, wb_regwrite_q, wb_regwrite_d;
  logic              wb_vec_q, wb_vec_d;
  logic [3:0]        wb_rd_q, wb_rd_d;
  logic [WORD_W-1:0] wb_data_q, wb_data_d;
  logic [VEC_W-1:0]  wb_dataV_q, wb_dataV_d;

  logic              accept, last, finish;
  logic [WORD_W-1:0] buf_word;
  logic [VEC_W-1:0]  buf_vec, merged;

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign last   = vec_q ? (beat_q == 2'd3) : (beat_q == 2'd0);

  vec_beat_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .load_en   (accept),
    .load_data (bus.VALUresult),
    .wr_en     ((state_q == RESP) && bus.mem_rvalid),
    .wr_idx    (beat_q),
    .wr_data   (bus.mem_rdata),
    .rd_idx    (beat_q),
    .rd_data   (buf_word),
    .data_o    (buf_vec)
  );

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    rd_d          = rd_q;
    regwrite_d    = regwrite_q;
    vec_d         = vec_q;
    we_d          = we_q;
    alu_d         = alu_q;
    wdata_d       = wdata_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    wb_valid_d    = 1'b0;
    wb_regwrite_d = wb_regwrite_q;
    wb_vec_d      = wb_vec_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    wb_dataV_d    = wb_dataV_q;
    finish        = 1'b0;
    // the final load beat lands in the same edge that fills the writeback
    merged        = set_beat(buf_vec, beat_q, bus.mem_rdata);

    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        beat_d     = '0;
        rd_d       = bus.Rd;
        regwrite_d = bus.RegWrite;
        vec_d      = bus.VecOp;
        we_d       = bus.MemWrite;
        alu_d      = bus.ALUresult;
        wdata_d    = bus.WriteData;
        if (bus.MemRead || bus.MemWrite) begin
          state_d   = REQ;
          mem_req_d = 1'b1;
          mem_we_d  = bus.MemWrite;
        end else begin
          state_d       = DONE;
          wb_valid_d    = 1'b1;
          wb_regwrite_d = bus.RegWrite;
          wb_vec_d      = bus.VecOp;
          wb_rd_d       = bus.Rd;
          wb_data_d     = bus.ALUresult;
          wb_dataV_d    = bus.VALUresult;
        end
      end
      REQ: if (bus.mem_gnt) begin
        if (!we_q) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
        end else if (last) finish = 1'b1;
        else               beat_d = beat_q + 2'd1;
      end
      RESP: if (bus.mem_rvalid) begin
        if (last) finish = 1'b1;
        else begin
          beat_d    = beat_q + 2'd1;
          state_d   = REQ;
          mem_req_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d       = DONE;
      mem_req_d     = 1'b0;
      wb_valid_d    = 1'b1;
      wb_regwrite_d = regwrite_q & ~we_q;
      wb_vec_d      = vec_q;
      wb_rd_d       = rd_q;
      wb_data_d     = we_q ? alu_q  : merged[WORD_W-1:0];
      wb_dataV_d    = we_q ? buf_vec : merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      rd_q          <= '0;
      regwrite_q    <= 1'b0;
      vec_q         <= 1'b0;
      we_q          <= 1'b0;
      alu_q         <= '0;
      wdata_q       <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_vec_q      <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      wb_dataV_q    <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      rd_q          <= rd_d;
      regwrite_q    <= regwrite_d;
      vec_q         <= vec_d;
      we_q          <= we_d;
      alu_q         <= alu_d;
      wdata_q       <= wdata_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_vec_q      <= wb_vec_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      wb_dataV_q    <= wb_dataV_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.stall       = (state_q != IDLE);
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = {alu_q[WORD_W-1:2], 2'b00} + {28'd0, beat_q, 2'b00};
  assign bus.mem_wdata   = vec_q ? buf_word : wdata_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_RegWrite = wb_regwrite_q;
  assign bus.wb_VecOp    = wb_vec_q;
  assign bus.wb_Rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_dataV    = wb_dataV_q;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: non-memory op, scalar load with wait
// states, vector store, wrapping vector load with stray handshakes, reset mid-op.
module tb_memory_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  memory_stage_if bus();

  memory_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.in_valid   = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.VecOp      = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.Rd         = 4'd0;
    bus.ALUresult  = 32'd0;
    bus.WriteData  = 32'd0;
    bus.VALUresult = 128'd0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
  endtask

  logic [31:0] st_addr [4];
  logic [31:0] st_data [4];
  logic [31:0] ld_addr [4];

  initial begin
    st_addr = '{32'h200, 32'h204, 32'h208, 32'h20C};
    st_data = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    ld_addr = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4};

    // reset state
    rst = 1'b1;
    clear_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_stall",    bus.stall,    0);
    check("rst_mem_req",  bus.mem_req,  0);
    check("rst_mem_we",   bus.mem_we,   0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_wdata",    bus.mem_wdata, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_wb_data",  bus.wb_data,  0);
    check("rst_wb_dataV", bus.wb_dataV, 0);
    tick();
    rst = 1'b0;

    // non-memory op
    bus.in_valid  = 1'b1;
    bus.RegWrite  = 1'b1;
    bus.Rd        = 4'd5;
    bus.ALUresult = 32'h12345678;
    bus.VALUresult = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    tick();
    clear_in();
    @(negedge clk);
    check("nm_wb_valid", bus.wb_valid, 1);
    check("nm_wb_data",  bus.wb_data,  32'h12345678);
    check("nm_wb_dataV", bus.wb_dataV, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0);
    check("nm_wb_Rd",    bus.wb_Rd,    5);
    check("nm_wb_RegWr", bus.wb_RegWrite, 1);
    check("nm_mem_req",  bus.mem_req,  0);
    check("nm_in_ready_done", bus.in_ready, 0);
    tick();
    @(negedge clk);
    check("nm_wb_valid_drop", bus.wb_valid, 0);
    check("nm_wb_data_hold",  bus.wb_data,  32'h12345678);
    check("nm_in_ready_back", bus.in_ready, 1);
    check("nm_mem_req_after", bus.mem_req,  0);

    // scalar load, gnt held off two cycles
    bus.in_valid  = 1'b1;
    bus.MemRead   = 1'b1;
    bus.RegWrite  = 1'b1;
    bus.Rd        = 4'd3;
    bus.ALUresult = 32'h103;
    tick();
    clear_in();
    @(negedge clk);
    check("sl_req0",   bus.mem_req,  1);
    check("sl_addr0",  bus.mem_addr, 32'h100);
    check("sl_we0",    bus.mem_we,   0);
    check("sl_stall0", bus.stall,    1);
    tick();
    @(negedge clk);
    check("sl_req1",   bus.mem_req,  1);
    check("sl_stall1", bus.stall,    1);
    tick();
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    check("sl_req2",   bus.mem_req,  1);
    check("sl_addr2",  bus.mem_addr, 32'h100);
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEADBEEF;
    @(negedge clk);
    check("sl_resp_req",   bus.mem_req, 0);
    check("sl_resp_stall", bus.stall,   1);
    tick();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    check("sl_wb_valid", bus.wb_valid, 1);
    check("sl_wb_data",  bus.wb_data,  32'hDEADBEEF);
    check("sl_wb_Rd",    bus.wb_Rd,    3);
    check("sl_wb_RegWr", bus.wb_RegWrite, 1);
    check("sl_stall_done", bus.stall,  1);
    tick();
    @(negedge clk);
    check("sl_in_ready", bus.in_ready, 1);

    // vector store, zero-wait grants
    bus.in_valid   = 1'b1;
    bus.MemWrite   = 1'b1;
    bus.VecOp      = 1'b1;
    bus.RegWrite   = 1'b1;
    bus.Rd         = 4'd2;
    bus.ALUresult  = 32'h200;
    bus.VALUresult = 128'h44444444_33333333_22222222_11111111;
    tick();
    clear_in();
    bus.mem_gnt = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check($sformatf("vs_req%0d", b),   bus.mem_req,   1);
      check($sformatf("vs_we%0d", b),    bus.mem_we,    1);
      check($sformatf("vs_addr%0d", b),  bus.mem_addr,  st_addr[b]);
      check($sformatf("vs_wdata%0d", b), bus.mem_wdata, st_data[b]);
      tick();
    end
    @(negedge clk);
    check("vs_wb_valid", bus.wb_valid,    1);
    check("vs_wb_RegWr", bus.wb_RegWrite, 0);
    check("vs_req_done", bus.mem_req,     0);
    tick();
    bus.mem_gnt = 1'b0;

    // stray rvalid in IDLE
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0BAD0;
    tick();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    check("stray_idle_wb_valid", bus.wb_valid, 0);
    check("stray_idle_wb_data",  bus.wb_data,  32'h200);
    check("stray_idle_req",      bus.mem_req,  0);

    // vector load wrapping past 0xFFFFFFFC, stray rvalid in REQ
    bus.in_valid   = 1'b1;
    bus.MemRead    = 1'b1;
    bus.VecOp      = 1'b1;
    bus.RegWrite   = 1'b1;
    bus.Rd         = 4'd7;
    bus.ALUresult  = 32'hFFFFFFF8;
    bus.VALUresult = {4{32'hFFFFFFFF}};
    tick();
    clear_in();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0BAD0;
    @(negedge clk);
    check("vl_stray_req",  bus.mem_req,  1);
    check("vl_stray_addr", bus.mem_addr, 32'hFFFFFFF8);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_gnt    = 1'b1;
    @(negedge clk);
    check("vl_stray_wb_valid", bus.wb_valid, 0);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) @(negedge clk);
      check($sformatf("vl_req%0d", b),  bus.mem_req,  1);
      check($sformatf("vl_addr%0d", b), bus.mem_addr, ld_addr[b]);
      tick();
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = b;
      @(negedge clk);
      check($sformatf("vl_resp_req%0d", b), bus.mem_req, 0);
      tick();
      bus.mem_rvalid = 1'b0;
      bus.mem_gnt    = (b < 3);
    end
    @(negedge clk);
    check("vl_wb_valid", bus.wb_valid, 1);
    check("vl_wb_dataV", bus.wb_dataV, 128'h00000003_00000002_00000001_00000000);
    check("vl_wb_VecOp", bus.wb_VecOp, 1);
    check("vl_wb_Rd",    bus.wb_Rd,    7);
    check("vl_wb_RegWr", bus.wb_RegWrite, 1);
    tick();

    // reset in the middle of a vector load
    bus.in_valid  = 1'b1;
    bus.MemRead   = 1'b1;
    bus.VecOp     = 1'b1;
    bus.RegWrite  = 1'b1;
    bus.Rd        = 4'd4;
    bus.ALUresult = 32'h300;
    tick();
    clear_in();
    for (int b = 0; b < 2; b++) begin
      bus.mem_gnt = 1'b1;
      tick();
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h5500 + b;
      tick();
      bus.mem_rvalid = 1'b0;
    end
    @(negedge clk);
    check("rm_req_beat2",  bus.mem_req,  1);
    check("rm_addr_beat2", bus.mem_addr, 32'h308);
    #2 rst = 1'b1;
    #1;
    check("rm_req_async",   bus.mem_req,  0);
    check("rm_in_ready",    bus.in_ready, 1);
    check("rm_stall",       bus.stall,    0);
    check("rm_wb_valid",    bus.wb_valid, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rm_wb_valid_after", bus.wb_valid, 0);
    check("rm_req_after",      bus.mem_req,  0);

    // following non-memory op completes normally
    bus.in_valid  = 1'b1;
    bus.RegWrite  = 1'b1;
    bus.Rd        = 4'd9;
    bus.ALUresult = 32'hCAFEF00D;
    tick();
    clear_in();
    @(negedge clk);
    check("rm_nm_wb_valid", bus.wb_valid, 1);
    check("rm_nm_wb_data",  bus.wb_data,  32'hCAFEF00D);
    check("rm_nm_wb_Rd",    bus.wb_Rd,    9);
    check("rm_nm_wb_VecOp", bus.wb_VecOp, 0);
    tick();
    @(negedge clk);
    check("rm_nm_wb_drop",  bus.wb_valid, 0);
    check("rm_nm_in_ready", bus.in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
